// File: rtl/store_buffer_be.sv
// In-order store buffer between the LSU and data memory: per-byte enables,
// optional merge into the youngest entry, and per-byte load forwarding.
module store_buffer_be #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned SLOTS     = 8,
    parameter int unsigned IDX_BITS  = 3,
    parameter int unsigned COALESCE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid,
    input  logic [ADDR_BITS-1:0]   push_addr,
    input  logic [DATA_BITS-1:0]   push_data,
    input  logic [DATA_BITS/8-1:0] push_be,
    output logic                   push_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_BITS-1:0]   ld_addr,
    input  logic [DATA_BITS/8-1:0] ld_be,
    output logic                   ld_hit,
    output logic                   ld_partial,
    output logic [DATA_BITS-1:0]   ld_data,
    output logic                   mem_valid,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_data,
    output logic [DATA_BITS/8-1:0] mem_be,
    input  logic                   mem_ready,
    output logic [IDX_BITS:0]      count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned NB  = DATA_BITS / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned WA  = ADDR_BITS - OFF;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [IDX_BITS:0]   cnt_t;

    logic [WA-1:0]        wa_q   [SLOTS];
    logic [DATA_BITS-1:0] data_q [SLOTS];
    logic [NB-1:0]        be_q   [SLOTS];

    idx_t head_q, head_d, tail_q, tail_d;
    cnt_t count_q, count_d;

    logic [WA-1:0] push_wa, ld_wa;
    idx_t          youngest;
    logic          coalesce_ok, push_acc, do_merge, do_alloc, retire;
    logic          unused_addr_lsbs;

    assign push_wa  = push_addr[ADDR_BITS-1:OFF];
    assign ld_wa    = ld_addr[ADDR_BITS-1:OFF];
    assign unused_addr_lsbs = ^{push_addr[OFF-1:0], ld_addr[OFF-1:0]};
    assign youngest = tail_q - idx_t'(1);

    // count>=2 keeps the merge target off the head, whose fields must stay stable
    assign coalesce_ok = (COALESCE != 0) && (count_q >= cnt_t'(2))
                         && (wa_q[youngest] == push_wa);

    assign empty      = (count_q == '0);
    assign full       = (count_q == cnt_t'(SLOTS));
    assign count      = count_q;
    assign push_ready = !full || coalesce_ok;
    assign push_acc   = push_valid && push_ready;
    assign do_merge   = push_acc && coalesce_ok;
    assign do_alloc   = push_acc && !coalesce_ok;

    assign mem_valid = !empty;
    assign mem_addr  = empty ? '0 : {wa_q[head_q], {OFF{1'b0}}};
    assign mem_data  = empty ? '0 : data_q[head_q];
    assign mem_be    = empty ? '0 : be_q[head_q];
    assign retire    = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire)   head_d = head_q + idx_t'(1);
            if (do_alloc) tail_d = tail_q + idx_t'(1);
            case ({do_alloc, retire})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (do_alloc) begin
                wa_q[tail_q]   <= push_wa;
                data_q[tail_q] <= push_data;
                be_q[tail_q]   <= push_be;
            end
            if (do_merge) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (push_be[b]) data_q[youngest][b*8 +: 8] <= push_data[b*8 +: 8];
                end
                be_q[youngest] <= be_q[youngest] | push_be;
            end
        end
    end

    logic [NB-1:0] covered;
    idx_t          slot;

    // Walk oldest to youngest so later matches overwrite: youngest byte wins.
    always_comb begin
        ld_data = '0;
        covered = '0;
        slot    = '0;
        if (ld_valid) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                slot = head_q + idx_t'(k);
                if ((cnt_t'(k) < count_q) && (wa_q[slot] == ld_wa)) begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if (ld_be[b] && be_q[slot][b]) begin
                            ld_data[b*8 +: 8] = data_q[slot][b*8 +: 8];
                            covered[b]        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ld_hit     = ld_valid && (covered == ld_be);
    assign ld_partial = (|covered) && !ld_hit;

endmodule

// File: tb/tb_store_buffer_be.sv
// Bench for store_buffer_be: directed sequences, a forwarding vector table and
// randomized traffic checked against a queue-based reference model.
module tb_store_buffer_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, push_valid, ld_valid, mem_ready;
    logic [31:0] push_addr, push_data, ld_addr;
    logic [3:0]  push_be, ld_be;
    logic        push_ready, ld_hit, ld_partial, mem_valid, empty, full;
    logic [31:0] ld_data, mem_addr, mem_data;
    logic [3:0]  mem_be, count;

    logic        push_ready_n, ld_hit_n, ld_partial_n, mem_valid_n, empty_n, full_n;
    logic [31:0] ld_data_n, mem_addr_n, mem_data_n;
    logic [3:0]  mem_be_n, count_n;

    store_buffer_be #(.DATA_BITS(32), .ADDR_BITS(32), .SLOTS(8), .IDX_BITS(3), .COALESCE(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .push_ready(push_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_partial(ld_partial), .ld_data(ld_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
        .mem_ready(mem_ready), .count(count), .empty(empty), .full(full)
    );

    store_buffer_be #(.DATA_BITS(32), .ADDR_BITS(32), .SLOTS(8), .IDX_BITS(3), .COALESCE(0)) u_nomerge (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .push_ready(push_ready_n),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit_n), .ld_partial(ld_partial_n), .ld_data(ld_data_n),
        .mem_valid(mem_valid_n), .mem_addr(mem_addr_n), .mem_data(mem_data_n), .mem_be(mem_be_n),
        .mem_ready(mem_ready), .count(count_n), .empty(empty_n), .full(full_n)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of entries, oldest at index 0.
    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;
    ent_t mq[$];

    function automatic bit can_merge();
        int n = mq.size();
        if (n < 2) return 1'b0;
        return mq[n-1].wa == push_addr[31:2];
    endfunction

    task automatic model_check();
        int          n = mq.size();
        bit          exp_ready = (n < 8) || can_merge();
        logic [31:0] d = '0;
        logic [3:0]  cov = '0;
        bit          hit, part;
        if (ld_valid) begin
            for (int b = 0; b < 4; b++) begin
                bit found = 1'b0;
                if (ld_be[b]) begin
                    for (int i = n - 1; i >= 0; i--) begin
                        if (!found && mq[i].wa == ld_addr[31:2] && mq[i].be[b]) begin
                            d[b*8 +: 8] = mq[i].d[b*8 +: 8];
                            cov[b] = 1'b1;
                            found = 1'b1;
                        end
                    end
                end
            end
        end
        hit  = ld_valid && (cov == ld_be);
        part = (cov != 0) && !hit;
        check("m.count", count, n);
        check("m.empty", empty, n == 0);
        check("m.full", full, n == 8);
        check("m.mem_valid", mem_valid, n != 0);
        check("m.push_ready", push_ready, exp_ready);
        check("m.ld_hit", ld_hit, hit);
        check("m.ld_partial", ld_partial, part);
        check("m.ld_data", ld_data, d);
        if (n != 0) begin
            check("m.mem_addr", mem_addr, {mq[0].wa, 2'b00});
            check("m.mem_data", mem_data, mq[0].d);
            check("m.mem_be", mem_be, mq[0].be);
        end
    endtask

    task automatic model_update();
        int   n = mq.size();
        bit   merge = can_merge();
        bit   acc = push_valid && ((n < 8) || merge);
        ent_t e;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (acc && merge) begin
                e = mq[n-1];
                for (int b = 0; b < 4; b++)
                    if (push_be[b]) e.d[b*8 +: 8] = push_data[b*8 +: 8];
                e.be = e.be | push_be;
                mq[n-1] = e;
            end
            if (n > 0 && mem_ready) void'(mq.pop_front());
            if (acc && !merge) begin
                e.wa = push_addr[31:2];
                e.d  = push_data;
                e.be = push_be;
                mq.push_back(e);
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs checked mid-cycle.
    task automatic step();
        #3;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush = 0; push_valid = 0; push_addr = '0; push_data = '0; push_be = '0;
        ld_valid = 0; ld_addr = '0; ld_be = '0; mem_ready = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        push_valid = 1; push_addr = a; push_data = d; push_be = be;
        step();
        push_valid = 0;
    endtask

    typedef struct packed {
        logic        pv;
        logic [31:0] pa;
        logic [31:0] pd;
        logic [3:0]  pbe;
        logic        mr;
        logic        lv;
        logic [31:0] la;
        logic [3:0]  lbe;
        logic [3:0]  ecount;
        logic        ehit;
        logic        epart;
        logic [31:0] edata;
    } vec_t;

    function automatic vec_t mk(logic pv, logic [31:0] pa, logic [31:0] pd, logic [3:0] pbe,
                                logic mr, logic lv, logic [31:0] la, logic [3:0] lbe,
                                logic [3:0] ec, logic eh, logic ep, logic [31:0] ed);
        return '{pv, pa, pd, pbe, mr, lv, la, lbe, ec, eh, ep, ed};
    endfunction

    vec_t        tab[13];
    logic [31:0] exp_a[8];
    logic [31:0] exp_d[8];

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        mq.delete();
        #1;
        check("rst.count", count, 0);
        check("rst.empty", empty, 1);
        check("rst.full", full, 0);
        check("rst.push_ready", push_ready, 1);
        check("rst.mem_valid", mem_valid, 0);

        // Single push, head held stable while memory stalls
        push(32'h100, 32'h11223344, 4'hF);
        check("t1.mem_valid", mem_valid, 1);
        check("t1.mem_addr", mem_addr, 32'h100);
        check("t1.count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1.hold_addr", mem_addr, 32'h100);
            check("t1.hold_data", mem_data, 32'h11223344);
            check("t1.hold_be", mem_be, 4'hF);
        end
        mem_ready = 1;
        step();
        mem_ready = 0;
        check("t1.empty", empty, 1);

        // Fill to full, refuse a ninth word, drain in order across the wrap
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 32'h1000 + 32'(i * 4);
            exp_d[i] = $urandom;
            push(exp_a[i], exp_d[i], 4'hF);
        end
        push_addr = 32'h2000;
        #1;
        check("t2.full", full, 1);
        check("t2.push_ready", push_ready, 0);
        push(32'h2000, 32'hDEADBEEF, 4'hF);
        check("t2.count_after_refuse", count, 8);
        mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("t2.drain_addr", mem_addr, exp_a[i]);
            check("t2.drain_data", mem_data, exp_d[i]);
            step();
        end
        mem_ready = 0;
        check("t2.empty", empty, 1);

        // Coalesce into youngest (non-head) entry
        push(32'h200, 32'h0000AABB, 4'h3);
        push(32'h300, 32'h00001122, 4'h3);
        push(32'h300, 32'hCCDD0000, 4'hC);
        check("t3.count", count, 2);
        check("t3.count_nomerge", count_n, 3);
        ld_valid = 1; ld_addr = 32'h300; ld_be = 4'hF;
        #1;
        check("t3.ld_hit", ld_hit, 1);
        check("t3.ld_data", ld_data, 32'hCCDD1122);
        ld_valid = 0;
        mem_ready = 1;
        #1;
        check("t3.head_addr", mem_addr, 32'h200);
        check("t3.head_be", mem_be, 4'h3);
        step();
        check("t3.merged_be", mem_be, 4'hF);
        check("t3.merged_data", mem_data, 32'hCCDD1122);
        step();
        mem_ready = 0;
        flush = 1;
        step();
        flush = 0;

        // Forwarding table: youngest-first per byte, partial hits, retiring head
        tab[0]  = mk(1, 32'h400, 32'h01020304, 4'hF, 0, 0, 32'h000, 4'h0, 0, 0, 0, 32'h0);
        tab[1]  = mk(1, 32'h400, 32'h000000FF, 4'h1, 0, 1, 32'h400, 4'hF, 1, 1, 0, 32'h01020304);
        tab[2]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h400, 4'hF, 2, 1, 0, 32'h010203FF);
        tab[3]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h404, 4'hF, 2, 0, 0, 32'h0);
        tab[4]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h400, 4'h1, 2, 1, 0, 32'h000000FF);
        tab[5]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h400, 4'hF, 2, 0, 0, 32'h0);
        tab[6]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h400, 4'hE, 2, 1, 0, 32'h01020300);
        tab[7]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h400, 4'hF, 1, 0, 1, 32'h000000FF);
        tab[8]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 1, 32'h400, 4'hF, 1, 0, 1, 32'h000000FF);
        tab[9]  = mk(1, 32'h500, 32'h1234ABCD, 4'h3, 0, 1, 32'h500, 4'hF, 0, 0, 0, 32'h0);
        tab[10] = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h500, 4'hF, 1, 0, 1, 32'h0000ABCD);
        tab[11] = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h500, 4'h3, 1, 1, 0, 32'h0000ABCD);
        tab[12] = mk(0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h500, 4'hC, 1, 0, 0, 32'h0);
        for (int i = 0; i < 13; i++) begin
            push_valid = tab[i].pv; push_addr = tab[i].pa; push_data = tab[i].pd;
            push_be = tab[i].pbe; mem_ready = tab[i].mr; ld_valid = tab[i].lv;
            ld_addr = tab[i].la; ld_be = tab[i].lbe;
            #1;
            check($sformatf("tbl%0d.count", i), count, tab[i].ecount);
            check($sformatf("tbl%0d.ld_hit", i), ld_hit, tab[i].ehit);
            check($sformatf("tbl%0d.ld_partial", i), ld_partial, tab[i].epart);
            check($sformatf("tbl%0d.ld_data", i), ld_data, tab[i].edata);
            step();
        end
        idle();
        flush = 1;
        step();
        flush = 0;

        // Retire does not free space for a same-cycle push; flush mid-drain
        for (int i = 0; i < 8; i++) push(32'h3000 + 32'(i * 4), $urandom, 4'hF);
        mem_ready = 1; push_valid = 1; push_addr = 32'h4000; push_data = 32'h55; push_be = 4'hF;
        #1;
        check("t6.push_ready_full", push_ready, 0);
        step();
        push_valid = 0;
        check("t6.count", count, 7);
        step();
        flush = 1;
        step();
        flush = 0; mem_ready = 0;
        check("t6.flush_empty", empty, 1);
        check("t6.flush_mem_valid", mem_valid, 0);
        check("t6.flush_count", count, 0);
        check("t6.flush_push_ready", push_ready, 1);

        // Random traffic against the model; mem_ready bias alternates to reach full
        for (int i = 0; i < 3000; i++) begin
            flush      = ($urandom_range(0, 63) == 0);
            push_valid = ($urandom_range(0, 9) < 6);
            push_addr  = 32'h600 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            push_data  = $urandom;
            push_be    = 4'($urandom_range(1, 15));
            ld_valid   = ($urandom_range(0, 3) != 0);
            ld_addr    = 32'h600 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            ld_be      = 4'($urandom_range(0, 15));
            if (((i / 500) % 2) == 0) mem_ready = ($urandom_range(0, 3) == 0);
            else                      mem_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
